// File: rtl/lsu_wb_stage_pkg.sv
// Shared encodings for the load/store writeback stage: access direction, access size,
// FSM state codes, the captured-operation record and the alignment rule.
package lsu_wb_stage_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;
  localparam logic [1:0] MEM_SIZE_D = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
  } mem_op_t;

  // A dword access is never legal on a 32-bit datapath, whatever its address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo,
                                         input logic dw64);
    case (size)
      MEM_SIZE_B: is_misaligned = 1'b0;
      MEM_SIZE_H: is_misaligned = addr_lo[0];
      MEM_SIZE_W: is_misaligned = |addr_lo[1:0];
      default:    is_misaligned = !dw64 || (|addr_lo);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: shifts store data and builds strobes on the way out, and
// extracts plus sign/zero-extends load data on the way back.
module lsu_align
  import lsu_wb_stage_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(STRB_W)
) (
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [OFF_W-1:0]      i_offset,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [STRB_W-1:0]     o_wstrb,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [STRB_W-1:0]     w_mask;
  logic [6:0]            w_nbits;
  logic                  w_sign;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_lo_mask;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_mask  = STRB_W'(8'h01);
    w_nbits = 7'd8;
    w_sign  = w_shifted[7];
    case (i_size)
      MEM_SIZE_H: begin
        w_mask  = STRB_W'(8'h03);
        w_nbits = 7'd16;
        w_sign  = w_shifted[15];
      end
      MEM_SIZE_W: begin
        w_mask  = STRB_W'(8'h0F);
        w_nbits = 7'd32;
        w_sign  = w_shifted[31];
      end
      MEM_SIZE_D: begin
        w_mask  = STRB_W'(8'hFF);
        w_nbits = 7'd64;
        w_sign  = w_shifted[DATA_WIDTH-1];
      end
      default: ;
    endcase
  end

  // A shift by the full width yields zero, so a full-width access gets an all-ones mask.
  assign w_lo_mask = ~({DATA_WIDTH{1'b1}} << w_nbits);

  assign o_rdata = (w_shifted & w_lo_mask)
                 | ({DATA_WIDTH{w_sign & ~i_unsigned}} & ~w_lo_mask);
  assign o_wstrb = w_mask << i_offset;
  assign o_wdata = i_wdata << {i_offset, 3'b000};

endmodule

// File: rtl/lsu_wb_stage.sv
// Load/store + writeback stage between EX and the GPR write port, driving a
// req/gnt/rvalid memory port with one access outstanding. DATA_WIDTH is 32 or 64.
module lsu_wb_stage
  import lsu_wb_stage_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int REG_AW     = 5,
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_mem_ena,
  input  logic                  ex_mem_rw,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_unsigned,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic [REG_AW-1:0]     ex_waddr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_W-1:0]     mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [REG_AW-1:0]     gprs_waddr_o,
  output logic [DATA_WIDTH-1:0] gprs_wdata_o,
  output logic                  stall,
  output logic                  misalign
);

  localparam int OFF_W = $clog2(STRB_W);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  mem_op_t               r_op;
  logic [OFF_W-1:0]      r_offset;
  logic [REG_AW-1:0]     r_waddr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  mem_op_t               w_ex_op;
  mem_op_t               w_op;
  logic [OFF_W-1:0]      w_offset;
  logic [ADDR_WIDTH-1:0] w_ex_addr_al;
  logic [STRB_W-1:0]     w_ex_wstrb;
  logic [DATA_WIDTH-1:0] w_al_wdata;
  logic [STRB_W-1:0]     w_al_wstrb;
  logic [DATA_WIDTH-1:0] w_al_rdata;
  logic w_idle, w_ex_mem, w_ex_misal, w_issue, w_bypass;
  logic w_req, w_we, w_acc, w_st_done, w_ld_done, w_busy;

  // Reset is folded into the decode so every output shows its idle value while rst is high.
  assign w_idle     = (r_state == ST_IDLE) && !rst;
  assign w_ex_mem   = w_idle && ex_valid && ex_mem_ena;
  assign w_ex_misal = is_misaligned(ex_mem_size, ex_addr[2:0], DATA_WIDTH == 64);
  assign w_issue    = w_ex_mem && !w_ex_misal;
  assign w_bypass   = w_idle && ex_valid && !ex_mem_ena;

  assign w_ex_op      = '{we: (ex_mem_rw == MEM_WRITE), size: ex_mem_size, uns: ex_mem_unsigned};
  assign w_ex_addr_al = {ex_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign w_ex_wstrb   = w_ex_op.we ? w_al_wstrb : '0;

  // In IDLE the op comes straight from EX (covers same-cycle gnt+rvalid); otherwise from the capture.
  assign w_op     = w_idle ? w_ex_op : r_op;
  assign w_offset = w_idle ? ex_addr[OFF_W-1:0] : r_offset;

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .i_size     (w_op.size),
    .i_unsigned (w_op.uns),
    .i_offset   (w_offset),
    .i_wdata    (ex_wdata),
    .i_rdata    (mem_rdata),
    .o_wdata    (w_al_wdata),
    .o_wstrb    (w_al_wstrb),
    .o_rdata    (w_al_rdata)
  );

  assign w_req     = w_issue || ((r_state == ST_REQ) && !rst);
  assign w_we      = w_req && w_op.we;
  assign w_acc     = w_req && mem_gnt;
  assign w_st_done = w_acc && w_we;
  assign w_ld_done = (w_acc && !w_we && mem_rvalid)
                   || ((r_state == ST_WAIT) && !rst && mem_rvalid);
  assign w_busy    = w_issue || ((r_state != ST_IDLE) && !rst);

  assign mem_req   = w_req;
  assign mem_we    = w_we;
  assign mem_addr  = w_idle ? w_ex_addr_al : r_addr;
  assign mem_wdata = w_idle ? w_al_wdata : r_wdata;
  assign mem_wstrb = !w_req ? '0 : (w_idle ? w_ex_wstrb : r_wstrb);
  assign stall     = w_busy && !(w_st_done || w_ld_done);
  assign misalign  = w_ex_mem && w_ex_misal;

  always_comb begin
    gprs_waddr_o = '0;
    gprs_wdata_o = '0;
    if (w_bypass) begin
      gprs_waddr_o = ex_waddr;
      gprs_wdata_o = ex_wdata;
    end else if (w_ld_done) begin
      gprs_waddr_o = w_idle ? ex_waddr : r_waddr;
      gprs_wdata_o = w_al_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          if (!mem_gnt)                    w_state_nxt = ST_REQ;
          else if (!w_we && !mem_rvalid)   w_state_nxt = ST_WAIT;
        end
      end
      ST_REQ: begin
        if (mem_gnt) w_state_nxt = (w_we || mem_rvalid) ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the capture registers carry no reset; they are only read after an issue has loaded them.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_op     <= w_ex_op;
      r_offset <= ex_addr[OFF_W-1:0];
      r_waddr  <= ex_waddr;
      r_addr   <= w_ex_addr_al;
      r_wdata  <= w_al_wdata;
      r_wstrb  <= w_ex_wstrb;
    end
  end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Scoreboard bench for lsu_wb_stage: a 32-bit and a 64-bit instance, directed vectors,
// expected memory/writeback/misalign events queued by stimulus and popped by monitors.
module tb_lsu_wb_stage;
  import lsu_wb_stage_pkg::*;

  localparam int EV_MEM = 0;
  localparam int EV_WB  = 1;
  localparam int EV_MIS = 2;

  typedef struct {
    int          kind;
    logic        we;
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  s;
  } ev_t;

  ev_t q32[$];
  ev_t q64[$];
  int  n_checks = 0;
  int  n_errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_ex_valid, a_ex_mem_ena, a_ex_mem_rw, a_ex_mem_unsigned;
  logic [1:0]  a_ex_mem_size;
  logic [31:0] a_ex_addr, a_ex_wdata;
  logic [4:0]  a_ex_waddr;
  logic        a_mem_req, a_mem_we, a_mem_gnt, a_mem_rvalid;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_wstrb;
  logic [4:0]  a_gprs_waddr;
  logic [31:0] a_gprs_wdata;
  logic        a_stall, a_misalign;

  logic        b_ex_valid, b_ex_mem_ena, b_ex_mem_rw, b_ex_mem_unsigned;
  logic [1:0]  b_ex_mem_size;
  logic [31:0] b_ex_addr;
  logic [63:0] b_ex_wdata;
  logic [4:0]  b_ex_waddr;
  logic        b_mem_req, b_mem_we, b_mem_gnt, b_mem_rvalid;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_wstrb;
  logic [4:0]  b_gprs_waddr;
  logic [63:0] b_gprs_wdata;
  logic        b_stall, b_misalign;

  lsu_wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst(rst),
    .ex_valid(a_ex_valid), .ex_mem_ena(a_ex_mem_ena), .ex_mem_rw(a_ex_mem_rw),
    .ex_mem_size(a_ex_mem_size), .ex_mem_unsigned(a_ex_mem_unsigned),
    .ex_addr(a_ex_addr), .ex_wdata(a_ex_wdata), .ex_waddr(a_ex_waddr),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_gnt(a_mem_gnt),
    .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata),
    .gprs_waddr_o(a_gprs_waddr), .gprs_wdata_o(a_gprs_wdata),
    .stall(a_stall), .misalign(a_misalign)
  );

  lsu_wb_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .REG_AW(5)) dut64 (
    .clk(clk), .rst(rst),
    .ex_valid(b_ex_valid), .ex_mem_ena(b_ex_mem_ena), .ex_mem_rw(b_ex_mem_rw),
    .ex_mem_size(b_ex_mem_size), .ex_mem_unsigned(b_ex_mem_unsigned),
    .ex_addr(b_ex_addr), .ex_wdata(b_ex_wdata), .ex_waddr(b_ex_waddr),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_gnt(b_mem_gnt),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
    .gprs_waddr_o(b_gprs_waddr), .gprs_wdata_o(b_gprs_wdata),
    .stall(b_stall), .misalign(b_misalign)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input bit d64, input ev_t e);
    if (d64) q64.push_back(e);
    else     q32.push_back(e);
  endtask

  task automatic observe(input bit d64, input ev_t got, input string tag);
    ev_t e;
    if ((d64 && q64.size() == 0) || (!d64 && q32.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_unexpected: got kind %0d addr %h data %h, expected no event",
               tag, got.kind, got.a, got.d);
      return;
    end
    if (d64) e = q64.pop_front();
    else     e = q32.pop_front();
    check({tag, "_kind"}, 64'(got.kind), 64'(e.kind));
    if (got.kind == e.kind) begin
      check({tag, "_addr"}, got.a, e.a);
      check({tag, "_data"}, got.d, e.d);
      if (got.kind == EV_MEM) begin
        check({tag, "_we"},   64'(got.we), 64'(e.we));
        check({tag, "_strb"}, 64'(got.s),  64'(e.s));
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t g;
    if (a_mem_req && a_mem_gnt) begin
      g = '{kind: EV_MEM, we: a_mem_we, a: 64'(a_mem_addr), d: 64'(a_mem_wdata), s: 8'(a_mem_wstrb)};
      observe(1'b0, g, "d32_mem");
    end
    if (a_gprs_waddr != 5'd0) begin
      g = '{kind: EV_WB, we: 1'b0, a: 64'(a_gprs_waddr), d: 64'(a_gprs_wdata), s: 8'h00};
      observe(1'b0, g, "d32_wb");
    end
    if (a_misalign) begin
      g = '{kind: EV_MIS, we: 1'b0, a: 64'd0, d: 64'd0, s: 8'h00};
      observe(1'b0, g, "d32_mis");
    end
  end

  always @(negedge clk) begin
    ev_t g;
    if (b_mem_req && b_mem_gnt) begin
      g = '{kind: EV_MEM, we: b_mem_we, a: 64'(b_mem_addr), d: b_mem_wdata, s: b_mem_wstrb};
      observe(1'b1, g, "d64_mem");
    end
    if (b_gprs_waddr != 5'd0) begin
      g = '{kind: EV_WB, we: 1'b0, a: 64'(b_gprs_waddr), d: b_gprs_wdata, s: 8'h00};
      observe(1'b1, g, "d64_wb");
    end
    if (b_misalign) begin
      g = '{kind: EV_MIS, we: 1'b0, a: 64'd0, d: 64'd0, s: 8'h00};
      observe(1'b1, g, "d64_mis");
    end
  end

  task automatic drive_ex(input bit d64, input logic valid, input logic ena, input logic rw,
                          input logic [1:0] size, input logic uns, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [4:0] waddr);
    if (d64) begin
      b_ex_valid = valid; b_ex_mem_ena = ena; b_ex_mem_rw = rw; b_ex_mem_size = size;
      b_ex_mem_unsigned = uns; b_ex_addr = addr; b_ex_wdata = wdata; b_ex_waddr = waddr;
    end else begin
      a_ex_valid = valid; a_ex_mem_ena = ena; a_ex_mem_rw = rw; a_ex_mem_size = size;
      a_ex_mem_unsigned = uns; a_ex_addr = addr; a_ex_wdata = wdata[31:0]; a_ex_waddr = waddr;
    end
  endtask

  task automatic set_mem(input bit d64, input logic gnt, input logic rvalid, input logic [63:0] rdata);
    if (d64) begin
      b_mem_gnt = gnt; b_mem_rvalid = rvalid; b_mem_rdata = rdata;
    end else begin
      a_mem_gnt = gnt; a_mem_rvalid = rvalid; a_mem_rdata = rdata[31:0];
    end
  endtask

  task automatic sample(input bit d64, output logic st, output logic rq, output logic [4:0] wa);
    if (d64) begin st = b_stall; rq = b_mem_req; wa = b_gprs_waddr; end
    else     begin st = a_stall; rq = a_mem_req; wa = a_gprs_waddr; end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access; gnt arrives in cycle gnt_c, rvalid (loads) in cycle rv_c, cycle 0 = issue cycle.
  task automatic access(input string tag, input bit d64, input logic rw, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [4:0] waddr, input int gnt_c, input int rv_c,
                        input logic [63:0] rdata, input logic [63:0] exp_d,
                        input logic [7:0] exp_s, input logic [63:0] exp_wb);
    int          last;
    logic        st, rq;
    logic [4:0]  wa;
    logic [31:0] al;
    last = (rw == MEM_WRITE) ? gnt_c : rv_c;
    al   = addr & (d64 ? ~32'h7 : ~32'h3);
    push(d64, '{kind: EV_MEM, we: rw, a: 64'(al), d: exp_d, s: exp_s});
    if (rw == MEM_READ && waddr != 5'd0)
      push(d64, '{kind: EV_WB, we: 1'b0, a: 64'(waddr), d: exp_wb, s: 8'h00});
    drive_ex(d64, 1'b1, 1'b1, rw, size, uns, addr, wdata, waddr);
    for (int c = 0; c <= last; c++) begin
      set_mem(d64, c == gnt_c, (rw == MEM_READ) && (c == rv_c), rdata);
      @(negedge clk);
      sample(d64, st, rq, wa);
      check({tag, "_stall"}, 64'(st), 64'(c != last));
      check({tag, "_req"},   64'(rq), 64'(c <= gnt_c));
      next_cycle();
    end
    drive_ex(d64, 1'b0, 1'b0, MEM_READ, MEM_SIZE_B, 1'b0, 32'd0, 64'd0, 5'd0);
    set_mem(d64, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic misaligned(input string tag, input bit d64, input logic [1:0] size,
                            input logic [31:0] addr);
    logic       st, rq;
    logic [4:0] wa;
    push(d64, '{kind: EV_MIS, we: 1'b0, a: 64'd0, d: 64'd0, s: 8'h00});
    drive_ex(d64, 1'b1, 1'b1, MEM_READ, size, 1'b0, addr, 64'd0, 5'd11);
    @(negedge clk);
    sample(d64, st, rq, wa);
    check({tag, "_stall"}, 64'(st), 64'd0);
    check({tag, "_req"},   64'(rq), 64'd0);
    check({tag, "_waddr"}, 64'(wa), 64'd0);
    next_cycle();
    drive_ex(d64, 1'b0, 1'b0, MEM_READ, MEM_SIZE_B, 1'b0, 32'd0, 64'd0, 5'd0);
  endtask

  task automatic bypass(input string tag, input logic [4:0] waddr, input logic [31:0] wdata);
    push(1'b0, '{kind: EV_WB, we: 1'b0, a: 64'(waddr), d: 64'(wdata), s: 8'h00});
    drive_ex(1'b0, 1'b1, 1'b0, MEM_READ, MEM_SIZE_W, 1'b0, 32'h0, 64'(wdata), waddr);
    @(negedge clk);
    check({tag, "_stall"}, 64'(a_stall), 64'd0);
    check({tag, "_req"},   64'(a_mem_req), 64'd0);
    next_cycle();
    drive_ex(1'b0, 1'b0, 1'b0, MEM_READ, MEM_SIZE_B, 1'b0, 32'd0, 64'd0, 5'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_ex(1'b0, 1'b0, 1'b0, MEM_READ, MEM_SIZE_B, 1'b0, 32'd0, 64'd0, 5'd0);
    drive_ex(1'b1, 1'b0, 1'b0, MEM_READ, MEM_SIZE_B, 1'b0, 32'd0, 64'd0, 5'd0);
    set_mem(1'b0, 1'b0, 1'b0, 64'd0);
    set_mem(1'b1, 1'b0, 1'b0, 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",      64'(a_mem_req),    64'd0);
    check("rst_stall",    64'(a_stall),      64'd0);
    check("rst_misalign", 64'(a_misalign),   64'd0);
    check("rst_waddr",    64'(a_gprs_waddr), 64'd0);
    check("rst_wdata",    64'(a_gprs_wdata), 64'd0);
    check("rst_wstrb",    64'(a_mem_wstrb),  64'd0);
    check("rst64_req",    64'(b_mem_req),    64'd0);
    check("rst64_stall",  64'(b_stall),      64'd0);
    next_cycle();
    rst = 1'b0;

    bypass("alu", 5'd5, 32'h0000_1234);

    //      tag    d64   rw         size        uns   addr      wdata           waddr gnt rv rdata              exp_d           strb   exp_wb
    access("lb",   1'b0, MEM_READ,  MEM_SIZE_B, 1'b0, 32'h103, 64'h0,          5'd7, 0, 3, 64'h80FF_0000,     64'h0,          8'h0,  64'hFFFF_FF80);
    access("lbu",  1'b0, MEM_READ,  MEM_SIZE_B, 1'b1, 32'h103, 64'h0,          5'd7, 0, 3, 64'h80FF_0000,     64'h0,          8'h0,  64'h0000_0080);
    access("sh",   1'b0, MEM_WRITE, MEM_SIZE_H, 1'b0, 32'h102, 64'hBEEF,       5'd0, 3, 0, 64'h0,             64'hBEEF_0000,  8'hC,  64'h0);
    access("sw",   1'b0, MEM_WRITE, MEM_SIZE_W, 1'b0, 32'h040, 64'hDEAD_BEEF,  5'd0, 0, 0, 64'h0,             64'hDEAD_BEEF,  8'hF,  64'h0);
    access("sb",   1'b0, MEM_WRITE, MEM_SIZE_B, 1'b0, 32'h041, 64'hA5,         5'd0, 1, 0, 64'h0,             64'h0000_A500,  8'h2,  64'h0);
    access("lh0",  1'b0, MEM_READ,  MEM_SIZE_H, 1'b0, 32'h012, 64'h0,          5'd8, 0, 0, 64'h8001_0000,     64'h0,          8'h0,  64'hFFFF_8001);
    access("lhu",  1'b0, MEM_READ,  MEM_SIZE_H, 1'b1, 32'h020, 64'h0,          5'd9, 1, 3, 64'h0000_9ABC,     64'h0,          8'h0,  64'h0000_9ABC);
    access("lwx0", 1'b0, MEM_READ,  MEM_SIZE_W, 1'b0, 32'h300, 64'h0,          5'd0, 0, 1, 64'h1234_5678,     64'h0,          8'h0,  64'h0);
    access("lw",   1'b0, MEM_READ,  MEM_SIZE_W, 1'b0, 32'h044, 64'h0,          5'd10,0, 1, 64'hCAFE_F00D,     64'h0,          8'h0,  64'hCAFE_F00D);

    misaligned("mis_lw", 1'b0, MEM_SIZE_W, 32'h101);
    misaligned("mis_lh", 1'b0, MEM_SIZE_H, 32'h103);
    misaligned("mis_sd", 1'b0, MEM_SIZE_D, 32'h008);

    // Reset while waiting for read data; the late rvalid must be dropped.
    push(1'b0, '{kind: EV_MEM, we: 1'b0, a: 64'h200, d: 64'h0, s: 8'h00});
    drive_ex(1'b0, 1'b1, 1'b1, MEM_READ, MEM_SIZE_W, 1'b0, 32'h200, 64'd0, 5'd12);
    set_mem(1'b0, 1'b1, 1'b0, 64'd0);
    @(negedge clk);
    check("rstw_issue_stall", 64'(a_stall), 64'd1);
    next_cycle();
    set_mem(1'b0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("rstw_wait_stall", 64'(a_stall),   64'd1);
    check("rstw_wait_req",   64'(a_mem_req), 64'd0);
    next_cycle();
    rst = 1'b1;
    drive_ex(1'b0, 1'b0, 1'b0, MEM_READ, MEM_SIZE_B, 1'b0, 32'd0, 64'd0, 5'd0);
    @(negedge clk);
    check("rstw_in_rst_stall", 64'(a_stall),   64'd0);
    check("rstw_in_rst_req",   64'(a_mem_req), 64'd0);
    next_cycle();
    rst = 1'b0;
    set_mem(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF);
    @(negedge clk);
    check("rstw_late_stall", 64'(a_stall),      64'd0);
    check("rstw_late_waddr", 64'(a_gprs_waddr), 64'd0);
    next_cycle();
    set_mem(1'b0, 1'b0, 1'b0, 64'd0);
    bypass("post_rst_alu", 5'd13, 32'h0000_0055);

    access("ld",   1'b1, MEM_READ,  MEM_SIZE_D, 1'b0, 32'h08,  64'h0,          5'd3, 0, 2, 64'h8000_0000_0000_0000, 64'h0, 8'h00, 64'h8000_0000_0000_0000);
    access("lw64", 1'b1, MEM_READ,  MEM_SIZE_W, 1'b0, 32'h0C,  64'h0,          5'd4, 0, 2, 64'h8000_0000_0000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_8000_0000);
    access("lwu64",1'b1, MEM_READ,  MEM_SIZE_W, 1'b1, 32'h0C,  64'h0,          5'd4, 1, 1, 64'h8000_0000_0000_0000, 64'h0, 8'h00, 64'h0000_0000_8000_0000);
    access("sd",   1'b1, MEM_WRITE, MEM_SIZE_D, 1'b0, 32'h10,  64'h1122_3344_5566_7788, 5'd0, 0, 0, 64'h0, 64'h1122_3344_5566_7788, 8'hFF, 64'h0);
    access("sw64", 1'b1, MEM_WRITE, MEM_SIZE_W, 1'b0, 32'h0C,  64'hAABB_CCDD,  5'd0, 1, 0, 64'h0, 64'hAABB_CCDD_0000_0000, 8'hF0, 64'h0);
    misaligned("mis_ld", 1'b1, MEM_SIZE_D, 32'h0C);

    repeat (2) next_cycle();
    check("sb32_drained", 64'(q32.size()), 64'd0);
    check("sb64_drained", 64'(q64.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
